// File: rtl/ram_dp_pkg.sv
// rtl/ram_dp_pkg.sv - shared state type and sizing helper for ram_dp_param
package ram_dp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Returns ceil(log2(n)), never less than 1, so a single-word RAM still gets a 1-bit pointer.
  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// rtl/ram_init_ctrl.sv - post-reset clear sweep FSM driving the RAM write port
module ram_init_ctrl
  import ram_dp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output logic             init_done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] clr_ptr;

  assign clr_we   = (state == INIT);
  assign clr_addr = clr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_ptr == LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - parametrised simple dual-port RAM with clear sweep and range checks
// RAM_DP_BYPASS_EN selects write-first on same-address collision; default build is read-first.
module ram_dp_param
  import ram_dp_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              addr_err,
  output logic              init_done
);

  localparam int              IDX_W   = clog2_f(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic              wr_ok;
  logic              rd_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  ram_init_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  assign wr_ok  = ({1'b0, write_addr} < DEPTH_A);
  assign rd_ok  = ({1'b0, read_addr} < DEPTH_A);
  assign rd_idx = read_addr[IDX_W-1:0];

  // The sweep owns the write port until it finishes; user requests are ignored meanwhile.
  assign mem_we    = clr_we | (init_done & write_en & wr_ok);
  assign mem_waddr = clr_we ? clr_addr : write_addr[IDX_W-1:0];
  assign mem_wdata = clr_we ? '0 : write_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef RAM_DP_BYPASS_EN
  logic collide;
  assign collide = write_en & wr_ok & (write_addr == read_addr);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
      if (init_done) begin
        addr_err <= (write_en & ~wr_ok) | (read_en & ~rd_ok);
        if (read_en) begin
          read_valid <= 1'b1;
          if (!rd_ok) begin
            read_data <= '0;
`ifdef RAM_DP_BYPASS_EN
          end else if (collide) begin
            read_data <= write_data;
`endif
          end else begin
            read_data <= mem[rd_idx];
          end
        end
      end
    end
  end

endmodule
